btn_repeat: RTL and testbench

// - Consumer of the two debounced paddle-button levels: turns each clean level into single-cycle step pulses.
// - One step on press; with auto-repeat built in, further steps at a fixed rate while held.
// - Sits between the button debouncer and the paddle position logic.
// - Opposing up/down buttons held together cancel each other.

---
 rtl/btn_repeat_pkg.sv | 19 +
 rtl/btn_repeat_ch.sv | 133 +++++++++++++
 rtl/btn_repeat.sv | 59 +++++
 tb/tb_btn_repeat.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/btn_repeat_pkg.sv
// Package shared by the paddle-button auto-repeat block.
// Holds the per-channel state encoding and the default timing constants
// (100 MHz system clock assumed for the defaults).
package btn_repeat_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } btn_state_t;

  // 300 ms until the first repeat, then one step every 50 ms.
  localparam int DEF_HOLD_DELAY    = 30_000_000;
  localparam int DEF_REPEAT_PERIOD = 5_000_000;
  localparam int DEF_CNT_W         = 25;

  localparam int NUM_CH = 2;

endpackage

// File: rtl/btn_repeat_ch.sv
// One button channel: turns a clean effective level into step pulses.
// The first step comes one cycle after the first sampled edge with eff=1.
// When BTN_REPEAT_EN is defined, further steps follow after HOLD_DELAY
// cycles and then every REPEAT_PERIOD cycles while the level stays high.
// When BTN_REPEAT_EN is undefined there is one step per press and no counter.
// Ports:
//   clk  - system clock, posedge
//   rst  - asynchronous active-high reset
//   eff  - effective pressed level (already conflict-masked)
//   step - one-cycle step pulse (registered)
//   held - registered, 1 while the channel is in HOLD or REPEAT
module btn_repeat_ch
  import btn_repeat_pkg::*;
#(
  parameter int HOLD_DELAY    = DEF_HOLD_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic eff,
  output logic step,
  output logic held
);

  btn_state_t state_reg;
  logic       step_reg;
  logic       held_reg;

`ifdef BTN_REPEAT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_DELAY - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic [CNT_W-1:0] cnt_reg;

  // Release is tested before terminal count so that dropping the button on
  // the terminal edge yields no step and returns straight to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      step_reg  <= 1'b0;
      held_reg  <= 1'b0;
    end else begin
      step_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          cnt_reg <= '0;
          if (eff) begin
            state_reg <= ST_HOLD;
            step_reg  <= 1'b1;
            held_reg  <= 1'b1;
          end else begin
            held_reg  <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (!eff) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            held_reg  <= 1'b0;
          end else if (cnt_reg == HOLD_LAST) begin
            state_reg <= ST_REPEAT;
            cnt_reg   <= '0;
            step_reg  <= 1'b1;
            held_reg  <= 1'b1;
          end else begin
            cnt_reg   <= cnt_reg + CNT_W'(1);
            held_reg  <= 1'b1;
          end
        end
        ST_REPEAT: begin
          if (!eff) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            held_reg  <= 1'b0;
          end else if (cnt_reg == REPEAT_LAST) begin
            cnt_reg   <= '0;
            step_reg  <= 1'b1;
            held_reg  <= 1'b1;
          end else begin
            cnt_reg   <= cnt_reg + CNT_W'(1);
            held_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          cnt_reg   <= '0;
          held_reg  <= 1'b0;
        end
      endcase
    end
  end
`else
  // Single-shot variant: HOLD simply waits for release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      step_reg  <= 1'b0;
      held_reg  <= 1'b0;
    end else begin
      step_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (eff) begin
            state_reg <= ST_HOLD;
            step_reg  <= 1'b1;
            held_reg  <= 1'b1;
          end else begin
            held_reg  <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (!eff) begin
            state_reg <= ST_IDLE;
            held_reg  <= 1'b0;
          end else begin
            held_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          held_reg  <= 1'b0;
        end
      endcase
    end
  end
`endif

  assign step = step_reg;
  assign held = held_reg;

endmodule

// File: rtl/btn_repeat.sv
// Paddle-button step generator: sits between the debouncer and the paddle
// position logic. Opposing buttons held together cancel; each remaining
// effective level drives one btn_repeat_ch channel.
// Optional feature: define BTN_REPEAT_EN for auto-repeat while held;
// without it each press gives exactly one step.
// Ports:
//   clk              - system clock, posedge
//   rst              - asynchronous active-high reset
//   btn_in_1/2       - debounced button levels (1 = pressed)
//   step_1/2         - one-cycle step pulses
//   held_1/2         - registered, 1 while the channel is in HOLD or REPEAT
module btn_repeat
  import btn_repeat_pkg::*;
#(
  parameter int HOLD_DELAY    = DEF_HOLD_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in_1,
  input  logic btn_in_2,
  output logic step_1,
  output logic step_2,
  output logic held_1,
  output logic held_2
);

  logic [NUM_CH-1:0] btn_vec;
  logic [NUM_CH-1:0] eff_vec;
  logic [NUM_CH-1:0] step_vec;
  logic [NUM_CH-1:0] held_vec;

  assign btn_vec = {btn_in_2, btn_in_1};

  // Each channel is masked by its opposite button; both pressed means
  // neither, so releasing one of a held pair looks like a fresh press.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign eff_vec[gi] = btn_vec[gi] & ~btn_vec[NUM_CH-1-gi];

    btn_repeat_ch #(
      .HOLD_DELAY    (HOLD_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD),
      .CNT_W         (CNT_W)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .eff  (eff_vec[gi]),
      .step (step_vec[gi]),
      .held (held_vec[gi])
    );
  end

  assign step_1 = step_vec[0];
  assign step_2 = step_vec[1];
  assign held_1 = held_vec[0];
  assign held_2 = held_vec[1];

endmodule

// File: tb/tb_btn_repeat.sv
// Bench for btn_repeat with HOLD_DELAY=8, REPEAT_PERIOD=4, CNT_W=4.
// The reference counts how many consecutive sampled edges each channel's
// effective level has been high ("age") and derives step/held from that age.
module tb_btn_repeat;

  localparam int HD = 8;
  localparam int RP = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_in_1 = 1'b0;
  logic btn_in_2 = 1'b0;
  logic step_1, step_2, held_1, held_2;

  int test_cnt = 0;
  int fail_cnt = 0;
  int age_1 = 0;
  int age_2 = 0;
  int step_cnt_1 = 0;

  always #5 clk = ~clk;

  btn_repeat #(
    .HOLD_DELAY    (HD),
    .REPEAT_PERIOD (RP),
    .CNT_W         (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_in_1 (btn_in_1),
    .btn_in_2 (btn_in_2),
    .step_1   (step_1),
    .step_2   (step_2),
    .held_1   (held_1),
    .held_2   (held_2)
  );

  // A step is owed on the first edge of a press and, with repeat enabled,
  // HD edges later and every RP edges thereafter.
  function automatic logic exp_step(input int age);
`ifdef BTN_REPEAT_EN
    return (age == 1) || (age > HD && ((age - 1 - HD) % RP) == 0);
`else
    return (age == 1);
`endif
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    test_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s t=%0t observed=%0b expected=%0b", tag, $time, obs, exp);
    end
  endtask

  // One clock: update the model from the levels sampled at posedge,
  // then compare all outputs at the following negedge.
  task automatic tick();
    logic e1, e2;
    @(posedge clk);
    e1 = btn_in_1 & ~btn_in_2;
    e2 = btn_in_2 & ~btn_in_1;
    if (rst) begin
      age_1 = 0;
      age_2 = 0;
    end else begin
      age_1 = e1 ? age_1 + 1 : 0;
      age_2 = e2 ? age_2 + 1 : 0;
    end
    @(negedge clk);
    check("step_1", step_1, exp_step(age_1));
    check("step_2", step_2, exp_step(age_2));
    check("held_1", held_1, logic'(age_1 > 0));
    check("held_2", held_2, logic'(age_2 > 0));
    if (step_1 === 1'b1) step_cnt_1++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // Reset held with button 1 pressed: everything stays 0.
    @(negedge clk);
    btn_in_1 = 1'b1;
    ticks(3);
    rst = 1'b0;
    ticks(3);
    btn_in_1 = 1'b0;
    ticks(3);

    // Short press: one step only.
    step_cnt_1 = 0;
    btn_in_1 = 1'b1;
    ticks(5);
    btn_in_1 = 1'b0;
    ticks(3);
    check("short_press_steps", logic'(step_cnt_1 == 1), 1'b1);

    // Long press: 30 edges.
    step_cnt_1 = 0;
    btn_in_1 = 1'b1;
    ticks(30);
    btn_in_1 = 1'b0;
    ticks(3);
`ifdef BTN_REPEAT_EN
    check("long_press_steps", logic'(step_cnt_1 == 7), 1'b1);
`else
    check("long_press_steps", logic'(step_cnt_1 == 1), 1'b1);
`endif

    // Conflict: both held cancel; releasing 1 makes 2 a fresh press.
    btn_in_1 = 1'b1;
    ticks(3);
    btn_in_2 = 1'b1;
    ticks(7);
    btn_in_1 = 1'b0;
    ticks(5);
    btn_in_2 = 1'b0;
    ticks(3);

    // Release on the terminal-count edge: 8 edges high, dropped on the 9th.
    step_cnt_1 = 0;
    btn_in_1 = 1'b1;
    ticks(HD);
    btn_in_1 = 1'b0;
    ticks(3);
    check("term_release_steps", logic'(step_cnt_1 == 1), 1'b1);

    // Randomised run with long-ish run lengths and one mid-run reset.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 9) == 0) btn_in_1 = ~btn_in_1;
      if ($urandom_range(0, 13) == 0) btn_in_2 = ~btn_in_2;
      if (i == 250) rst = 1'b1;
      if (i == 252) rst = 1'b0;
      tick();
    end
    btn_in_1 = 1'b0;
    btn_in_2 = 1'b0;
    ticks(3);

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
